// File: rtl/uart_line_reader_pkg.sv
// Shared terminal definitions: control characters, printable bounds, line reader FSM states.
package uart_line_reader_pkg;

  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_DEL      = 8'h7F;
  localparam logic [7:0] CH_SP       = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ECHO    = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/uart_line_reader_if.sv
// Line reader bus: rx buffer pop side, tx buffer push side, and the consumer line port.
interface uart_line_reader_if #(
  parameter int unsigned MAX_LEN = 32
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  logic             rx_get;
  logic [7:0]       rx_data;
  logic             rx_empty;
  logic             tx_put;
  logic [7:0]       tx_data;
  logic             tx_empty;
  logic             line_valid;
  logic [LEN_W-1:0] line_len;
  logic             overflow;
  logic             line_ack;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;

  // Reader side
  modport master (
    output rx_get, tx_put, tx_data, line_valid, line_len, overflow, rd_data,
    input  rx_data, rx_empty, tx_empty, line_ack, rd_idx
  );

  // Environment side (buffers and consumer)
  modport slave (
    input  rx_get, tx_put, tx_data, line_valid, line_len, overflow, rd_data,
    output rx_data, rx_empty, tx_empty, line_ack, rd_idx
  );
endinterface

// File: rtl/uart_line_reader_mem.sv
// Line storage: MAX_LEN x 8 register array, one write port, registered bound-checked read port.
module uart_line_mem #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned IDX_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [LEN_W-1:0] i_line_len,
  output logic [7:0]       o_rd_data
);
  logic [7:0] r_mem [MAX_LEN];
  logic [7:0] r_rd_data;

  // Character storage; contents after reset are don't-care
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; indices past the current line length read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 8'h00;
    end else if (LEN_W'(i_rd_idx) < i_line_len) begin
      r_rd_data <= r_mem[i_rd_idx];
    end else begin
      r_rd_data <= 8'h00;
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/uart_line_reader.sv
// Command line assembler: pops rx bytes, applies edits, holds the finished line for the consumer.
// Optional echo of edits to the tx buffer when UART_LINE_READER_ECHO_EN is defined.
module uart_line_reader
  import uart_line_reader_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  uart_line_reader_if.master bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  state_e           r_state, w_state_d;
  logic [LEN_W-1:0] r_len, w_len_d;
  logic             r_ovf, w_ovf_d;
  logic             r_cr, w_cr_d;
  logic             w_consume, w_we, w_term, w_echo_req;
  logic [7:0]       w_b;
  logic [2:0][7:0]  w_echo_bytes;
  logic [1:0]       w_echo_n;

  assign w_b        = bus.rx_data;
  // Gated by rst_n so no pop is requested while held in reset
  assign bus.rx_get = rst_n && (r_state == S_COLLECT);
  assign w_consume  = bus.rx_get && !bus.rx_empty;

  assign bus.line_valid = (r_state == S_DONE);
  assign bus.line_len   = r_len;
  assign bus.overflow   = r_ovf;

  // Decode the consumed byte into store/edit/terminate actions and the echo it produces
  always_comb begin
    w_len_d      = r_len;
    w_ovf_d      = r_ovf;
    w_cr_d       = r_cr;
    w_we         = 1'b0;
    w_term       = 1'b0;
    w_echo_req   = 1'b0;
    w_echo_bytes = '0;
    w_echo_n     = 2'd0;
    if (w_consume) begin
      w_cr_d = 1'b0;
      if (is_printable(w_b)) begin
        if (r_len < LEN_W'(MAX_LEN)) begin
          w_we            = 1'b1;
          w_len_d         = r_len + 1'b1;
          w_echo_req      = 1'b1;
          w_echo_bytes[0] = w_b;
          w_echo_n        = 2'd1;
        end else begin
          w_ovf_d = 1'b1;
        end
      end else if (w_b == CH_BS || w_b == CH_DEL) begin
        if (r_len != '0) begin
          w_len_d      = r_len - 1'b1;
          w_echo_req   = 1'b1;
          w_echo_bytes = {CH_BS, CH_SP, CH_BS};
          w_echo_n     = 2'd3;
        end
      end else if (w_b == CH_CR || (w_b == CH_LF && !r_cr)) begin
        // LF right after CR is the second half of a CRLF pair and is swallowed
        w_cr_d       = (w_b == CH_CR);
        w_term       = 1'b1;
        w_echo_req   = 1'b1;
        w_echo_bytes = {8'h00, CH_LF, CH_CR};
        w_echo_n     = 2'd2;
      end
    end else if (r_state == S_DONE && bus.line_ack) begin
      w_len_d = '0;
      w_ovf_d = 1'b0;
    end
  end

`ifdef UART_LINE_READER_ECHO_EN
  logic [2:0][7:0] r_echo_q, w_echo_q_d;
  logic [1:0]      r_echo_cnt, w_echo_cnt_d;
  logic            r_echo_go, w_echo_go_d;
  logic            r_echo_term, w_echo_term_d;
  logic            w_put;

  // FSM next state; echo burst starts once tx is empty and then runs back-to-back
  always_comb begin
    w_state_d     = r_state;
    w_echo_q_d    = r_echo_q;
    w_echo_cnt_d  = r_echo_cnt;
    w_echo_go_d   = r_echo_go;
    w_echo_term_d = r_echo_term;
    w_put         = 1'b0;
    unique case (r_state)
      S_COLLECT: begin
        if (w_echo_req) begin
          w_state_d     = S_ECHO;
          w_echo_q_d    = w_echo_bytes;
          w_echo_cnt_d  = w_echo_n;
          w_echo_term_d = w_term;
          w_echo_go_d   = 1'b0;
        end
      end
      S_ECHO: begin
        if (bus.tx_empty || r_echo_go) begin
          w_put        = 1'b1;
          w_echo_go_d  = 1'b1;
          w_echo_q_d   = {8'h00, r_echo_q[2], r_echo_q[1]};
          w_echo_cnt_d = r_echo_cnt - 2'd1;
          if (r_echo_cnt == 2'd1) begin
            w_echo_go_d = 1'b0;
            w_state_d   = r_echo_term ? S_DONE : S_COLLECT;
          end
        end
      end
      S_DONE: begin
        if (bus.line_ack) w_state_d = S_COLLECT;
      end
      default: w_state_d = S_COLLECT;
    endcase
  end

  // Echo queue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_q    <= '0;
      r_echo_cnt  <= 2'd0;
      r_echo_go   <= 1'b0;
      r_echo_term <= 1'b0;
    end else begin
      r_echo_q    <= w_echo_q_d;
      r_echo_cnt  <= w_echo_cnt_d;
      r_echo_go   <= w_echo_go_d;
      r_echo_term <= w_echo_term_d;
    end
  end

  assign bus.tx_put  = w_put;
  assign bus.tx_data = w_put ? r_echo_q[0] : 8'h00;
`else
  logic w_unused_echo;

  // FSM next state without echo: terminate goes straight to S_DONE
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_COLLECT: if (w_term) w_state_d = S_DONE;
      S_DONE:    if (bus.line_ack) w_state_d = S_COLLECT;
      default:   w_state_d = S_COLLECT;
    endcase
  end

  assign bus.tx_put    = 1'b0;
  assign bus.tx_data   = 8'h00;
  assign w_unused_echo = bus.tx_empty ^ w_echo_req ^ (^w_echo_bytes) ^ (^w_echo_n);
`endif

  // State, line length, overflow and CR-seen registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_cr    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_ovf   <= w_ovf_d;
      r_cr    <= w_cr_d;
    end
  end

  uart_line_mem #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .IDX_W   (IDX_W)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (r_len[IDX_W-1:0]),
    .i_wdata    (w_b),
    .i_rd_idx   (bus.rd_idx),
    .i_line_len (r_len),
    .o_rd_data  (bus.rd_data)
  );
endmodule
